// File: rtl/systolic_input_feeder_pkg.sv
// Shared types and helpers for the systolic array input feeder.
// Imported by the feeder top module.
package systolic_input_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_e;

  // Cycles needed after the last row enters lane 0 until its final column tag has fired.
  function automatic int drain_len(input int a_l, input int w_l);
    return a_l + w_l - 1;
  endfunction

endpackage

// File: rtl/systolic_input_feeder_if.sv
// Activation row stream into the systolic input feeder.
// A row transfers on a rising clock edge where s_valid and s_ready are both high; s_data and s_last
// are qualified by s_valid, s_ready never depends on s_valid, and s_last marks the final row of a tile.
interface systolic_input_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ARRAY_A_L  = 4
);
  logic                  s_valid;
  logic                  s_ready;
  logic                  s_last;
  logic [DATA_WIDTH-1:0] s_data [0:ARRAY_A_L-1];

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/systolic_input_feeder_skew_line.sv
// Never-stalled, zero-reset shift register; DEPTH=0 degenerates to a wire.
// o_taps exposes the last NTAPS stages, oldest stage at the highest index.
module systolic_skew_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter int NTAPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_taps [NTAPS]
);

  if (DEPTH == 0) begin : g_wire
    for (genvar i = 0; i < NTAPS; i++) begin : g_tap
      assign o_taps[i] = i_data;
    end
  end else begin : g_reg
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else begin
        r_stage[0] <= i_data;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    // Stage i is i+1 cycles behind i_data.
    for (genvar i = 0; i < NTAPS; i++) begin : g_tap
      assign o_taps[i] = r_stage[DEPTH-NTAPS+i];
    end
  end

endmodule

// File: rtl/systolic_input_feeder.sv
// Transmit side of the systolic array: skews activation rows onto the array lanes and tags finished columns.
// Optional SYSTOLIC_FEEDER_PERF_EN adds row_cnt / bubble_cnt outputs.
module systolic_input_feeder
  import systolic_input_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ARRAY_A_L  = 4,
  parameter int ARRAY_W_L  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  systolic_input_feeder_if.slave s_if,
  output logic                  weights_load,
  output logic [DATA_WIDTH-1:0] input_data [0:ARRAY_A_L-1],
  output logic [ARRAY_A_L-1:0]  lane_valid,
  output logic [ARRAY_W_L-1:0]  result_valid,
  output feeder_state_e         o_dbg_state
`ifdef SYSTOLIC_FEEDER_PERF_EN
  ,
  output logic [31:0]           row_cnt,
  output logic [31:0]           bubble_cnt
`endif
);

  localparam int DRAIN_LEN = drain_len(ARRAY_A_L, ARRAY_W_L);
  localparam int CW        = $clog2(DRAIN_LEN + 1);

  feeder_state_e r_state;
  feeder_state_e w_next;
  logic [CW-1:0] r_drain_cnt;
  logic          w_hs;

  assign w_hs        = s_if.s_valid & s_if.s_ready;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    weights_load = 1'b0;
    s_if.s_ready = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = WLOAD;
      end
      WLOAD: begin
        weights_load = 1'b1;
        w_next       = STREAM;
      end
      STREAM: begin
        s_if.s_ready = 1'b1;
        if (s_if.s_valid && s_if.s_last) w_next = DRAIN;
      end
      DRAIN: begin
        if (r_drain_cnt == '0) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain_cnt <= '0;
    end else if (r_state == STREAM && w_next == DRAIN) begin
      r_drain_cnt <= CW'(DRAIN_LEN);
    end else if (r_state == DRAIN && r_drain_cnt != '0) begin
      r_drain_cnt <= r_drain_cnt - 1'b1;
    end
  end

  // Lane j is one capture stage plus j skew stages; non-handshake cycles inject zero bubbles.
  for (genvar j = 0; j < ARRAY_A_L; j++) begin : g_lane
    logic [DATA_WIDTH-1:0] w_in_data;
    logic [DATA_WIDTH:0]   w_lane_tap [1];

    assign w_in_data = w_hs ? s_if.s_data[j] : {DATA_WIDTH{1'b0}};

    systolic_skew_line #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (j + 1),
      .NTAPS (1)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_data ({w_hs, w_in_data}),
      .o_taps (w_lane_tap)
    );

    assign input_data[j] = w_lane_tap[0][DATA_WIDTH-1:0];
    assign lane_valid[j] = w_lane_tap[0][DATA_WIDTH];
  end

  // Column t of the array finishes a row ARRAY_A_L+t cycles after its lane 0 element enters.
  logic [0:0] w_tag_tap [ARRAY_W_L];

  systolic_skew_line #(
    .WIDTH (1),
    .DEPTH (ARRAY_A_L + ARRAY_W_L - 1),
    .NTAPS (ARRAY_W_L)
  ) u_tag (
    .clk    (clk),
    .rst    (rst),
    .i_data (lane_valid[0:0]),
    .o_taps (w_tag_tap)
  );

  for (genvar t = 0; t < ARRAY_W_L; t++) begin : g_tag
    assign result_valid[t] = w_tag_tap[t][0];
  end

`ifdef SYSTOLIC_FEEDER_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt    <= '0;
      bubble_cnt <= '0;
    end else if (r_state == WLOAD) begin
      row_cnt    <= '0;
      bubble_cnt <= '0;
    end else if (r_state == STREAM) begin
      if (w_hs) row_cnt    <= row_cnt + 32'd1;
      else      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
